// File: rtl/seg_scan_driver_if.sv
// Load/result/display bundle for seg_scan_driver: binary value in,
// BCD result and multiplexed 7-segment drive out.
interface seg_scan_driver_if;
    logic [6:0]  value;
    logic        load;
    logic        busy;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  an;

    modport master (output value, load, input busy, bcd, seg, an);
    modport slave  (input value, load, output busy, bcd, seg, an);
endinterface

// File: rtl/seg_scan_driver.sv
// 7-bit binary to 3-digit BCD converter (double-dabble, one iteration per
// clock) driving a multiplexed, leading-zero-blanked 7-segment display.
module seg_scan_driver #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    seg_scan_driver_if.slave bus
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  iter, iter_nxt;
    logic [6:0]  bin_q, bin_nxt;
    logic [11:0] sh_q, sh_nxt;
    logic [11:0] bcd_q, bcd_nxt;
    logic [11:0] adj;
    logic [18:0] shifted;

    logic [PW-1:0] presc;
    logic [1:0]    digit;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    lit;

    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            adj[i*4 +: 4] = (sh_q[i*4 +: 4] >= 4'd5) ? sh_q[i*4 +: 4] + 4'd3
                                                    : sh_q[i*4 +: 4];
        end
        shifted = {adj, bin_q} << 1;

        state_nxt = state;
        iter_nxt  = iter;
        bin_nxt   = bin_q;
        sh_nxt    = sh_q;
        bcd_nxt   = bcd_q;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    state_nxt = SHIFT;
                    bin_nxt   = bus.value;
                    sh_nxt    = '0;
                    iter_nxt  = '0;
                end
            end
            SHIFT: begin
                sh_nxt   = shifted[18:7];
                bin_nxt  = shifted[6:0];
                iter_nxt = iter + 3'd1;
                // Seventh iteration: publish directly so partial sums never reach bcd.
                if (iter_nxt == 3'd7) begin
                    state_nxt = IDLE;
                    bcd_nxt   = shifted[18:7];
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            iter  <= '0;
            bin_q <= '0;
            sh_q  <= '0;
            bcd_q <= '0;
        end else begin
            state <= state_nxt;
            iter  <= iter_nxt;
            bin_q <= bin_nxt;
            sh_q  <= sh_nxt;
            bcd_q <= bcd_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            digit <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            digit <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        nib   = '0;
        blank = 1'b1;
        bus.an = '0;
        case (digit)
            2'd0: begin
                nib    = bcd_q[3:0];
                blank  = 1'b0;
                bus.an = 3'b001;
            end
            2'd1: begin
                nib    = bcd_q[7:4];
                blank  = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
                bus.an = 3'b010;
            end
            2'd2: begin
                nib    = bcd_q[11:8];
                blank  = (bcd_q[11:8] == 4'd0);
                bus.an = 3'b100;
            end
            default: ;
        endcase

        case (nib)
            4'd0:    lit = 7'b0111111;
            4'd1:    lit = 7'b0000110;
            4'd2:    lit = 7'b1011011;
            4'd3:    lit = 7'b1001111;
            4'd4:    lit = 7'b1100110;
            4'd5:    lit = 7'b1101101;
            4'd6:    lit = 7'b1111101;
            4'd7:    lit = 7'b0000111;
            4'd8:    lit = 7'b1111111;
            4'd9:    lit = 7'b1101111;
            default: lit = 7'b0000000;
        endcase
        if (blank) begin
            lit = '0;
        end
        bus.seg = SEG_ACTIVE_LOW ? ~lit : lit;
    end

    assign bus.busy = (state == SHIFT);
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized and directed bench for seg_scan_driver against an arithmetic
// model of conversion latency, BCD value and display scan.
module tb_seg_scan_driver;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst;
    int unsigned checks   = 0;
    int unsigned failures = 0;

    seg_scan_driver_if bus ();

    seg_scan_driver #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Active-low digit patterns, gfedcba
    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};

    function automatic logic [11:0] to_bcd(int unsigned v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(logic [11:0] b, int unsigned d);
        logic [3:0] h, t, o, nib;
        bit blank;
        h = b[11:8]; t = b[7:4]; o = b[3:0];
        case (d)
            0:       begin nib = o; blank = 1'b0; end
            1:       begin nib = t; blank = (h == 0) && (t == 0); end
            default: begin nib = h; blank = (h == 0); end
        endcase
        if (blank || nib > 9) return 7'b1111111;
        return pat[nib];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: conversion is a 7-edge countdown, display digit is
    // simply edges-since-reset divided by the refresh period, modulo 3.
    int unsigned m_left;
    int unsigned m_cycles;
    logic [11:0] m_bcd, m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left   <= 0;
            m_cycles <= 0;
            m_bcd    <= '0;
        end else begin
            m_cycles <= m_cycles + 1;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_bcd <= m_pend;
            end else if (bus.load) begin
                m_left <= 7;
                m_pend <= to_bcd(int'(bus.value));
            end
        end
    end

    initial begin
        logic [2:0]  prev_an, exp_an;
        int unsigned run, d;
        bit          run_valid;
        run = 0; run_valid = 0; prev_an = '0;
        forever begin
            @(negedge clk);
            d      = (m_cycles / DIV) % 3;
            exp_an = 3'b001 << d;
            check("busy", bus.busy, m_left != 0);
            check("bcd", bus.bcd, m_bcd);
            check("an", bus.an, exp_an);
            check("seg", bus.seg, exp_seg(m_bcd, d));
            if (rst) begin
                run_valid = 0; run = 0; prev_an = bus.an;
            end else if (bus.an != prev_an) begin
                if (run_valid) check("an_hold_len", run, DIV);
                check("an_rotate", bus.an, {prev_an[1:0], prev_an[2]});
                run_valid = 1; run = 1; prev_an = bus.an;
            end else begin
                run++;
            end
        end
    end

    task automatic pulse(input int unsigned v);
        bus.value = 7'(v);
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && bus.busy; k++) @(negedge clk);
        check("idle_timeout", bus.busy, 1'b0);
    endtask

    initial begin
        int unsigned n;
        bus.load  = 1'b0;
        bus.value = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_bcd", bus.bcd, 12'h000);
        check("rst_an", bus.an, 3'b001);
        check("rst_seg", bus.seg, 7'b1000000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // First edge after reset release accepts the load
        pulse(127);
        n = 0;
        for (int k = 0; k < 20 && bus.busy; k++) begin n++; @(negedge clk); end
        check("busy_len_127", n, 7);
        check("bcd_127", bus.bcd, 12'h127);

        pulse(5);
        wait_idle();
        check("bcd_5", bus.bcd, 12'h005);
        for (int k = 0; k < 12; k++) begin
            if (bus.an == 3'b001) check("seg5_ones", bus.seg, 7'b0010010);
            else                  check("seg5_blank", bus.seg, 7'b1111111);
            @(negedge clk);
        end

        pulse(99);
        bus.value = 7'd3;
        bus.load  = 1'b1;
        repeat (3) @(negedge clk);
        bus.load  = 1'b0;
        wait_idle();
        check("bcd_99_kept", bus.bcd, 12'h099);
        pulse(3);
        wait_idle();
        check("bcd_3", bus.bcd, 12'h003);

        // Load held across completion: ignored at N+7, accepted at N+8
        bus.value = 7'd58;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.value = 7'd61;
        repeat (6) @(negedge clk);
        check("busy_before_n7", bus.busy, 1'b1);
        @(negedge clk);
        check("busy_fall_n7", bus.busy, 1'b0);
        check("bcd_58", bus.bcd, 12'h058);
        @(negedge clk);
        check("reaccept_n8", bus.busy, 1'b1);
        bus.load = 1'b0;
        wait_idle();
        check("bcd_61", bus.bcd, 12'h061);

        pulse(127);
        wait_idle();
        pulse(88);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_bcd", bus.bcd, 12'h000);
        check("abort_an", bus.an, 3'b001);
        check("abort_seg", bus.seg, 7'b1000000);
        @(negedge clk);
        rst = 1'b0;
        pulse(42);
        wait_idle();
        check("bcd_42", bus.bcd, 12'h042);

        repeat (400) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) begin
                bus.load = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                bus.load  = ($urandom_range(0, 2) == 0);
                bus.value = 7'($urandom_range(0, 127));
            end
        end
        bus.load = 1'b0;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
- REQ-001: Parameter REFRESH_DIV, default 50000; clk cycles each digit stays lit, legal range >= 2.
- REQ-002: Parameter SEG_ACTIVE_LOW, default 1; 1 = segment lit when its bit is 0, 0 = lit when its bit is 1.
- REQ-003: clk  input  1  single system clock; all state updates on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: value  input  7  unsigned binary count, 0..127, sampled on an accepted load.
- REQ-006: load  input  1  conversion request, sampled each rising edge.
- REQ-007: busy  output  1  high while a conversion is in progress.
- REQ-008: bcd  output  12  last completed result: [11:8] hundreds, [7:4] tens, [3:0] ones.
- REQ-009: seg  output  7  segment bus, order gfedcba, seg[0] = a.
- REQ-010: an  output  3  one-hot digit enable, active-high: an[0] ones, an[1] tens, an[2] hundreds.

Function
- REQ-011: A load is accepted on a rising edge only when load=1 and busy=0; value is captured on that edge and busy rises after it.
- REQ-012: Conversion is shift-and-add-3 (double-dabble): 7 iterations, one per cycle; each iteration adds 3 to every BCD nibble >= 5, then shifts left one bit.
- REQ-013: Latency: with acceptance at edge N, iterations run on edges N+1..N+7; bcd updates and busy falls at edge N+7, so busy is high for exactly 7 cycles.
- REQ-014: load=1 while busy=1 is ignored, including on the completion edge N+7; a new load is accepted from edge N+8 onward.
- REQ-015: Converter FSM states are IDLE and SHIFT; IDLE goes to SHIFT on an accepted load, and SHIFT goes to IDLE when the 3-bit iteration counter reaches 7.
- REQ-016: bcd holds its value between conversions; intermediate shift-register contents never reach bcd, seg or an.
- REQ-017: The refresh prescaler counts 0..REFRESH_DIV-1 continuously, independent of load and busy; on wrap, the digit index advances 0 -> 1 -> 2 -> 0.
- REQ-018: an is the one-hot decode of the digit index; seg shows the selected nibble of the registered bcd.
- REQ-019: Digit patterns, SEG_ACTIVE_LOW=1: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; with SEG_ACTIVE_LOW=0 each pattern is bitwise inverted.
- REQ-020: Leading-zero blanking: hundreds is blank when it is 0; tens is blank when hundreds and tens are both 0; ones is never blanked.
- REQ-021: Blank drives all segments off, i.e. 1111111 when SEG_ACTIVE_LOW=1.
- REQ-022: Any nibble > 9 displays as blank; this case is unreachable from a 7-bit input but is handled defensively.
- REQ-023: A bcd update takes effect on the digit being scanned in the cycle after the update, with no change to scan timing.

Reset
- REQ-024: While rst=1, asynchronously: FSM = IDLE, busy=0, bcd=12'h000, iteration counter=0, prescaler=0, digit index=0.
- REQ-025: Output values during and after reset: an=001 and seg = pattern for 0 (1000000 when SEG_ACTIVE_LOW=1).
- REQ-026: rst asserted during SHIFT aborts the conversion; the partial result is discarded and bcd stays 000.
- REQ-027: The first load can be accepted on the first rising edge after rst deasserts.

Verification (REFRESH_DIV=4, SEG_ACTIVE_LOW=1)
- REQ-028: Bench SHALL cover: assert rst -> busy=0, bcd=000, an=001, seg=1000000 without any clock edge.
- REQ-029: Bench SHALL cover: value=127, load pulsed 1 cycle -> busy high exactly 7 cycles; bcd=12'h127 when busy falls.
- REQ-030: Bench SHALL cover: value=5 converted -> ones scan seg=0010010, tens and hundreds scans seg=1111111.
- REQ-031: Bench SHALL cover: value=99 loaded, then load held high with value=3 for 3 cycles of busy -> bcd=12'h099; the next load after busy falls yields 12'h003.
- REQ-032: Bench SHALL cover: rst pulsed during the 3rd SHIFT cycle of value=88 -> busy=0 and bcd=000 immediately; then load value=42 -> bcd=12'h042.
- REQ-033: Bench SHALL cover: free-running scan -> an sequence 001, 010, 100, 001, each held exactly 4 cycles, unchanged across load activity.
